// File: rtl/clk_gen_pkg.sv
// ---------------------------------------------------------------------------
// clk_gen_pkg
// Shared constants and types for the DMA clock-manager stand-in
// (clk_gen_dcm and its lock sequencer clk_gen_lock_seq).
//   CG_LOCK_CYCLES_DEF : default number of released edges before LOCKED
//   CG_VALID_DELAY_DEF : default LOCKED -> CLK_VALID delay in cycles
//   CG_CNT_W           : lock-counter width (covers LOCK_CYCLES up to 65535)
//   cgLockState_t      : lock sequencer state
// ---------------------------------------------------------------------------
package clk_gen_pkg;

    localparam int CG_LOCK_CYCLES_DEF = 64;
    localparam int CG_VALID_DELAY_DEF = 2;
    localparam int CG_CNT_W           = 16;

    typedef enum logic [1:0] {
        CG_RESET   = 2'd0,
        CG_LOCKING = 2'd1,
        CG_LOCKED  = 2'd2
    } cgLockState_t;

endpackage

// File: rtl/clk_gen_lock_seq.sv
// ---------------------------------------------------------------------------
// clk_gen_lock_seq
// Lock sequencer for clk_gen_dcm: counts released clock edges, raises
// o_locked LOCK_CYCLES edges after the first edge with i_reset low, and
// delays it by VALID_DELAY cycles to form o_clkValid.
// Ports:
//   i_clk      : pci_clk_in, the buffered PCI clock
//   i_reset    : synchronous active-high reset
//   o_locked   : registered lock indication
//   o_clkValid : o_locked delayed by VALID_DELAY cycles, cleared by reset
// ---------------------------------------------------------------------------
module clk_gen_lock_seq
    import clk_gen_pkg::*;
#(
    parameter int LOCK_CYCLES = CG_LOCK_CYCLES_DEF,
    parameter int VALID_DELAY = CG_VALID_DELAY_DEF
) (
    input  logic i_clk,
    input  logic i_reset,
    output logic o_locked,
    output logic o_clkValid
);

    localparam logic [CG_CNT_W-1:0] LAST_COUNT = CG_CNT_W'(LOCK_CYCLES - 1);

    cgLockState_t            r_state;
    cgLockState_t            w_stateNext;
    logic [CG_CNT_W-1:0]     r_count;
    logic [CG_CNT_W-1:0]     w_countNext;
    logic                    r_locked;
    logic [VALID_DELAY-1:0]  r_validSr;

    // State and counter registers; reset discards any partial count.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= CG_RESET;
            r_count <= '0;
        end else begin
            r_state <= w_stateNext;
            r_count <= w_countNext;
        end
    end

    // The first released edge only leaves CG_RESET; counting starts on the
    // next edge, so the lock lands exactly LOCK_CYCLES edges after the first
    // edge with reset low. Once locked the counter holds without wrapping.
    always_comb begin
        w_stateNext = r_state;
        w_countNext = r_count;
        case (r_state)
            CG_RESET: begin
                w_stateNext = CG_LOCKING;
            end
            CG_LOCKING: begin
                if (r_count == LAST_COUNT) begin
                    w_stateNext = CG_LOCKED;
                end else begin
                    w_countNext = r_count + CG_CNT_W'(1);
                end
            end
            CG_LOCKED: begin
                w_stateNext = CG_LOCKED;
            end
            default: begin
                w_stateNext = CG_RESET;
            end
        endcase
    end

    // LOCKED gets its own flop so the output never decodes a multi-bit
    // state transition. The valid shift register is cleared together with
    // LOCKED, so CLK_VALID falls on the same edge with no delay.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_locked  <= 1'b0;
            r_validSr <= '0;
        end else begin
            r_locked  <= (w_stateNext == CG_LOCKED);
            r_validSr <= (r_validSr << 1) | VALID_DELAY'(r_locked);
        end
    end

    assign o_locked   = r_locked;
    assign o_clkValid = r_validSr[VALID_DELAY-1];

endmodule

// File: rtl/clk_gen_dcm.sv
// ---------------------------------------------------------------------------
// clk_gen_dcm
// Behavioural/synthesizable stand-in for the DMA clock-manager primitive.
// Buffers the PCI clock, derives a half-rate Wishbone clock and a 1x
// Wishbone "2x" clock, and reports LOCKED / CLK_VALID status.
// Ports:
//   CLK_IN1    : raw PCI reference clock
//   RESET      : synchronous active-high reset, sampled on pci_clk_in
//   CLK_IN_BUF : buffered CLK_IN1 (pci_clk_in)
//   CLK_OUT1   : CLK_IN1/2, 50% duty
//   CLK_OUT2   : same frequency as CLK_IN1
//   LOCKED     : output clocks stable
//   CLK_VALID  : LOCKED delayed by VALID_DELAY cycles
// Build option:
//   CLK_GEN_OUT_GATE_EN : hold CLK_OUT1/CLK_OUT2 low until LOCKED. When
//                         undefined, both outputs run freely.
// ---------------------------------------------------------------------------
module clk_gen_dcm
    import clk_gen_pkg::*;
#(
    parameter int LOCK_CYCLES = CG_LOCK_CYCLES_DEF,
    parameter int VALID_DELAY = CG_VALID_DELAY_DEF
) (
    input  logic CLK_IN1,
    input  logic RESET,
    output logic CLK_IN_BUF,
    output logic CLK_OUT1,
    output logic CLK_OUT2,
    output logic LOCKED,
    output logic CLK_VALID
);

    logic pci_clk_in;
    logic w_locked;
    logic r_phase;

    // Pure buffer: no logic and no gating, so it runs through reset.
    assign pci_clk_in = CLK_IN1;
    assign CLK_IN_BUF = pci_clk_in;

    clk_gen_lock_seq #(
        .LOCK_CYCLES (LOCK_CYCLES),
        .VALID_DELAY (VALID_DELAY)
    ) u_lockSeq (
        .i_clk      (pci_clk_in),
        .i_reset    (RESET),
        .o_locked   (w_locked),
        .o_clkValid (CLK_VALID)
    );

    assign LOCKED = w_locked;

    // Divide-by-two phase flop; first rising output edge lands on the
    // first released input edge.
    always_ff @(posedge pci_clk_in) begin
        if (RESET) begin
            r_phase <= 1'b0;
        end else begin
            r_phase <= ~r_phase;
        end
    end

`ifdef CLK_GEN_OUT_GATE_EN
    logic r_gateN;

    // Capturing LOCKED while the clock is low means the gate only opens
    // between pulses, so the first CLK_OUT2 pulse is always full width.
    always_ff @(negedge pci_clk_in) begin
        r_gateN <= w_locked;
    end

    assign CLK_OUT1 = r_phase & w_locked;
    assign CLK_OUT2 = pci_clk_in & r_gateN;
`else
    assign CLK_OUT1 = r_phase;
    assign CLK_OUT2 = pci_clk_in;
`endif

endmodule

// File: tb/tb_clk_gen_dcm.sv
// ---------------------------------------------------------------------------
// tb_clk_gen_dcm
// Self-checking bench for clk_gen_dcm. The reference model counts edges
// with RESET low since the last edge that sampled RESET high and derives
// every expected output from that count.
// ---------------------------------------------------------------------------
module tb_clk_gen_dcm;

    localparam int L  = 64;
    localparam int VD = 2;

    logic CLK_IN1 = 1'b0;
    logic RESET   = 1'b1;
    logic CLK_IN_BUF;
    logic CLK_OUT1;
    logic CLK_OUT2;
    logic LOCKED;
    logic CLK_VALID;

    int checks   = 0;
    int errors   = 0;
    int edgeIdx  = -1;
    int relEdges = 0;
    bit mGate    = 1'b0;

    clk_gen_dcm #(
        .LOCK_CYCLES (L),
        .VALID_DELAY (VD)
    ) dut (
        .CLK_IN1    (CLK_IN1),
        .RESET      (RESET),
        .CLK_IN_BUF (CLK_IN_BUF),
        .CLK_OUT1   (CLK_OUT1),
        .CLK_OUT2   (CLK_OUT2),
        .LOCKED     (LOCKED),
        .CLK_VALID  (CLK_VALID)
    );

    always #5 CLK_IN1 = ~CLK_IN1;

    // Reference model: released-edge count since the last reset edge.
    always @(posedge CLK_IN1) begin
        edgeIdx = edgeIdx + 1;
        if (RESET) relEdges = 0;
        else       relEdges = relEdges + 1;
    end

    // Model of the output gate: lock status seen while the clock is low.
    always @(negedge CLK_IN1) begin
        mGate = (relEdges > L);
    end

    function automatic bit expLocked();
        return relEdges > L;
    endfunction

    function automatic bit expValid();
        return relEdges > L + VD;
    endfunction

    function automatic bit expOut1();
`ifdef CLK_GEN_OUT_GATE_EN
        return ((relEdges % 2) == 1) && (relEdges > L);
`else
        return (relEdges % 2) == 1;
`endif
    endfunction

    function automatic bit expOut2(input bit clkLevel);
`ifdef CLK_GEN_OUT_GATE_EN
        return clkLevel && mGate;
`else
        return clkLevel;
`endif
    endfunction

    // RESET high for edges 0..127, released after edge 127.
    task automatic test_reset();
        $display("[TB] test_reset");
        RESET = 1'b1;
        for (int i = 0; i < 128; i++) begin
            @(posedge CLK_IN1); #1;
            checks++; if (LOCKED !== 1'b0) begin errors++; $display("[TB] FAIL reset_locked e%0d: got %b exp 0", edgeIdx, LOCKED); end
            checks++; if (CLK_VALID !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid e%0d: got %b exp 0", edgeIdx, CLK_VALID); end
            checks++; if (CLK_OUT1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_out1 e%0d: got %b exp 0", edgeIdx, CLK_OUT1); end
            checks++; if (CLK_IN_BUF !== CLK_IN1) begin errors++; $display("[TB] FAIL reset_buf_hi e%0d: got %b exp %b", edgeIdx, CLK_IN_BUF, CLK_IN1); end
            if (i > 0) begin
                checks++; if (CLK_OUT2 !== expOut2(CLK_IN1)) begin errors++; $display("[TB] FAIL reset_out2 e%0d: got %b exp %b", edgeIdx, CLK_OUT2, expOut2(CLK_IN1)); end
            end
            @(negedge CLK_IN1); #1;
            checks++; if (CLK_IN_BUF !== CLK_IN1) begin errors++; $display("[TB] FAIL reset_buf_lo e%0d: got %b exp %b", edgeIdx, CLK_IN_BUF, CLK_IN1); end
        end
        RESET = 1'b0;
    endtask

    // From release at edge 128: LOCKED must rise at 192, CLK_VALID at 194.
    task automatic test_lock_sequence();
        int firstLock;
        int firstValid;
        $display("[TB] test_lock_sequence");
        firstLock  = -1;
        firstValid = -1;
        while (edgeIdx < 200) begin
            @(posedge CLK_IN1); #1;
            if (LOCKED === 1'b1 && firstLock < 0) firstLock = edgeIdx;
            if (CLK_VALID === 1'b1 && firstValid < 0) firstValid = edgeIdx;
            checks++; if (LOCKED !== expLocked()) begin errors++; $display("[TB] FAIL seq_locked e%0d: got %b exp %b", edgeIdx, LOCKED, expLocked()); end
            checks++; if (CLK_VALID !== expValid()) begin errors++; $display("[TB] FAIL seq_valid e%0d: got %b exp %b", edgeIdx, CLK_VALID, expValid()); end
            checks++; if (CLK_OUT1 !== expOut1()) begin errors++; $display("[TB] FAIL seq_out1 e%0d: got %b exp %b", edgeIdx, CLK_OUT1, expOut1()); end
            checks++; if (CLK_OUT2 !== expOut2(CLK_IN1)) begin errors++; $display("[TB] FAIL seq_out2_hi e%0d: got %b exp %b", edgeIdx, CLK_OUT2, expOut2(CLK_IN1)); end
            @(negedge CLK_IN1); #1;
            checks++; if (CLK_IN_BUF !== CLK_IN1) begin errors++; $display("[TB] FAIL seq_buf e%0d: got %b exp %b", edgeIdx, CLK_IN_BUF, CLK_IN1); end
            checks++; if (CLK_OUT2 !== 1'b0) begin errors++; $display("[TB] FAIL seq_out2_lo e%0d: got %b exp 0", edgeIdx, CLK_OUT2); end
        end
        checks++; if (firstLock !== 192) begin errors++; $display("[TB] FAIL lock_edge: got %0d exp 192", firstLock); end
        checks++; if (firstValid !== 194) begin errors++; $display("[TB] FAIL valid_edge: got %0d exp 194", firstValid); end
    endtask

    // 20 CLK_OUT1 periods measured in half input periods; CLK_OUT2 follows
    // the input clock level at every half.
    task automatic test_divider();
        bit s[$];
        int p;
        int h;
        int l;
        $display("[TB] test_divider");
        for (int c = 0; c < 44; c++) begin
            @(posedge CLK_IN1); #1;
            s.push_back(CLK_OUT1);
            checks++; if (CLK_OUT2 !== 1'b1) begin errors++; $display("[TB] FAIL div_out2_hi e%0d: got %b exp 1", edgeIdx, CLK_OUT2); end
            @(negedge CLK_IN1); #1;
            s.push_back(CLK_OUT1);
            checks++; if (CLK_OUT2 !== 1'b0) begin errors++; $display("[TB] FAIL div_out2_lo e%0d: got %b exp 0", edgeIdx, CLK_OUT2); end
        end
        p = 1;
        while (p < s.size() && !(s[p] == 1'b1 && s[p-1] == 1'b0)) p++;
        for (int k = 0; k < 20; k++) begin
            h = 0;
            l = 0;
            while (p < s.size() && s[p] == 1'b1) begin h++; p++; end
            while (p < s.size() && s[p] == 1'b0) begin l++; p++; end
            checks++; if (h + l != 4) begin errors++; $display("[TB] FAIL div_period %0d: got %0d halves exp 4", k, h + l); end
            checks++; if (h != l) begin errors++; $display("[TB] FAIL div_duty %0d: high %0d low %0d halves", k, h, l); end
        end
    endtask

    // One-cycle RESET pulses during locking, including one edge before lock.
    task automatic test_mid_reset();
        int k;
        int pulseEdge;
        int firstLock;
        $display("[TB] test_mid_reset");
        for (int it = 0; it < 4; it++) begin
            if (it == 0)      k = 31;
            else if (it == 1) k = L;
            else              k = $urandom_range(L, 1);
            RESET = 1'b1;
            repeat (2) begin @(posedge CLK_IN1); #1; end
            RESET = 1'b0;
            repeat (k) begin
                @(posedge CLK_IN1); #1;
                checks++; if (LOCKED !== expLocked()) begin errors++; $display("[TB] FAIL mid_prelock e%0d: got %b exp %b", edgeIdx, LOCKED, expLocked()); end
            end
            RESET = 1'b1;
            @(posedge CLK_IN1); #1;
            pulseEdge = edgeIdx;
            RESET = 1'b0;
            checks++; if (LOCKED !== 1'b0) begin errors++; $display("[TB] FAIL mid_pulse_locked e%0d: got %b exp 0", edgeIdx, LOCKED); end
            firstLock = -1;
            repeat (L + 8) begin
                @(posedge CLK_IN1); #1;
                if (LOCKED === 1'b1 && firstLock < 0) firstLock = edgeIdx;
                checks++; if (LOCKED !== expLocked()) begin errors++; $display("[TB] FAIL mid_locked e%0d: got %b exp %b", edgeIdx, LOCKED, expLocked()); end
                checks++; if (CLK_OUT1 !== expOut1()) begin errors++; $display("[TB] FAIL mid_out1 e%0d: got %b exp %b", edgeIdx, CLK_OUT1, expOut1()); end
            end
            checks++; if (firstLock !== pulseEdge + 1 + L) begin errors++; $display("[TB] FAIL mid_relock k=%0d: got %0d exp %0d", k, firstLock, pulseEdge + 1 + L); end
        end
    endtask

    // RESET while locked: everything drops on that edge, then relock.
    task automatic test_locked_reset();
        int n;
        int relEdge;
        int firstLock;
        int firstValid;
        $display("[TB] test_locked_reset");
        for (int it = 0; it < 2; it++) begin
            n = $urandom_range(4, 1);
            RESET = 1'b1;
            @(posedge CLK_IN1); #1;
            checks++; if (LOCKED !== 1'b0) begin errors++; $display("[TB] FAIL lr_locked e%0d: got %b exp 0", edgeIdx, LOCKED); end
            checks++; if (CLK_VALID !== 1'b0) begin errors++; $display("[TB] FAIL lr_valid e%0d: got %b exp 0", edgeIdx, CLK_VALID); end
            checks++; if (CLK_OUT1 !== 1'b0) begin errors++; $display("[TB] FAIL lr_out1 e%0d: got %b exp 0", edgeIdx, CLK_OUT1); end
            repeat (n - 1) begin @(posedge CLK_IN1); #1; end
            RESET = 1'b0;
            relEdge    = edgeIdx + 1;
            firstLock  = -1;
            firstValid = -1;
            repeat (L + VD + 6) begin
                @(posedge CLK_IN1); #1;
                if (LOCKED === 1'b1 && firstLock < 0) firstLock = edgeIdx;
                if (CLK_VALID === 1'b1 && firstValid < 0) firstValid = edgeIdx;
                checks++; if (LOCKED !== expLocked()) begin errors++; $display("[TB] FAIL lr_seq_locked e%0d: got %b exp %b", edgeIdx, LOCKED, expLocked()); end
                checks++; if (CLK_VALID !== expValid()) begin errors++; $display("[TB] FAIL lr_seq_valid e%0d: got %b exp %b", edgeIdx, CLK_VALID, expValid()); end
            end
            checks++; if (firstLock !== relEdge + L) begin errors++; $display("[TB] FAIL lr_relock: got %0d exp %0d", firstLock, relEdge + L); end
            checks++; if (firstValid !== relEdge + L + VD) begin errors++; $display("[TB] FAIL lr_revalid: got %0d exp %0d", firstValid, relEdge + L + VD); end
        end
    endtask

`ifdef CLK_GEN_OUT_GATE_EN
    // Outputs held low before lock; first CLK_OUT2 pulse is full width.
    task automatic test_gate();
        int relEdge;
        int firstOut2;
        bit o2a;
        bit o2b;
        bit o2c;
        $display("[TB] test_gate");
        RESET = 1'b1;
        repeat (2) begin @(posedge CLK_IN1); #1; end
        RESET = 1'b0;
        relEdge   = edgeIdx + 1;
        firstOut2 = -1;
        repeat (L + 6) begin
            @(posedge CLK_IN1); #1;
            o2a = CLK_OUT2; #1;
            o2b = CLK_OUT2; #2;
            o2c = CLK_OUT2;
            if (o2a && firstOut2 < 0) firstOut2 = edgeIdx;
            checks++; if (o2a !== mGate || o2b !== mGate || o2c !== mGate) begin errors++; $display("[TB] FAIL gate_out2_pulse e%0d: got %b%b%b exp %b%b%b", edgeIdx, o2a, o2b, o2c, mGate, mGate, mGate); end
            checks++; if (CLK_OUT1 !== expOut1()) begin errors++; $display("[TB] FAIL gate_out1 e%0d: got %b exp %b", edgeIdx, CLK_OUT1, expOut1()); end
            @(negedge CLK_IN1); #1;
            checks++; if (CLK_OUT2 !== 1'b0) begin errors++; $display("[TB] FAIL gate_out2_lo e%0d: got %b exp 0", edgeIdx, CLK_OUT2); end
        end
        checks++; if (firstOut2 !== relEdge + L + 1) begin errors++; $display("[TB] FAIL gate_first_out2: got %0d exp %0d", firstOut2, relEdge + L + 1); end
    endtask
`else
    // Ungated: CLK_OUT1 toggles from the first released edge while unlocked.
    task automatic test_free_run();
        $display("[TB] test_free_run");
        RESET = 1'b1;
        repeat (2) begin @(posedge CLK_IN1); #1; end
        RESET = 1'b0;
        for (int j = 1; j <= 10; j++) begin
            @(posedge CLK_IN1); #1;
            checks++; if (CLK_OUT1 !== ((j % 2) == 1)) begin errors++; $display("[TB] FAIL free_out1 j%0d: got %b exp %b", j, CLK_OUT1, (j % 2) == 1); end
            checks++; if (LOCKED !== 1'b0) begin errors++; $display("[TB] FAIL free_locked j%0d: got %b exp 0", j, LOCKED); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_lock_sequence();
        test_divider();
        test_mid_reset();
        test_locked_reset();
`ifdef CLK_GEN_OUT_GATE_EN
        test_gate();
`else
        test_free_run();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_gen_dcm.md
Name: clk_gen_dcm

Overview:
Behavioural/synthesizable stand-in for the DMA clock-manager primitive wrapper. It buffers the PCI input clock, derives a Wishbone clock at half the input rate and a 2x clock at the input rate, and reports lock and valid status. The parent clock/reset block drives RESET (a power-up pulse of 128 PCI cycles) and uses LOCKED to generate the Wishbone resets.

Parameters:
LOCK_CYCLES, 64, number of pci_clk_in rising edges after RESET deassertion before LOCKED asserts (range 1..65535)
VALID_DELAY, 2, pci_clk_in cycles from LOCKED rising to CLK_VALID rising (range 1..15)

Ports:
CLK_IN1  input  1  raw PCI reference clock
RESET  input  1  synchronous active-high reset, sampled on pci_clk_in
CLK_IN_BUF  output  1  buffered CLK_IN1 (pci_clk_in); the block's internal clock
CLK_OUT1  output  1  Wishbone clock, CLK_IN1/2, 50% duty
CLK_OUT2  output  1  Wishbone 2x clock, same frequency as CLK_IN1
LOCKED  output  1  high when output clocks are stable
CLK_VALID  output  1  high VALID_DELAY cycles after LOCKED; outputs safe to use

Behaviour:
- Reset RESET, synchronous, active-high; clock pci_clk_in. pci_clk_in = CLK_IN1 through a buffer only: zero logic, never gated, also valid during RESET.
- All state updates on the rising edge of pci_clk_in, except the CLK_OUT2 gate flop, which updates on the falling edge.
- Reset values, effective on the edge that samples RESET=1:
  - lock counter = 0
  - LOCKED = 0
  - CLK_VALID = 0 and valid-delay shift register = 0
  - divider phase = 0, so CLK_OUT1 is low
- Lock sequencing:
  - While RESET=0 and LOCKED=0, the counter increments each edge.
  - When the counter reaches LOCK_CYCLES-1, LOCKED is registered high, so it is first high on edge LOCK_CYCLES after the first edge with RESET=0.
  - Once locked, the counter holds (saturates) with no wrap.
- Reset mid-operation: RESET=1 at any point restarts the whole sequence. If locked, LOCKED drops on that same edge. A partial count is discarded.
- CLK_VALID: LOCKED passes through a VALID_DELAY-stage shift register and is cleared by RESET. It falls together with LOCKED, with no delay on deassertion.
- Divider: the phase flop toggles every rising edge while RESET=0. CLK_OUT1 = phase, giving period 2x input, 50% duty, and a first rising edge one cycle after reset release.
- CLK_OUT2 = pci_clk_in, subject to the gate below.
- RESET and LOCKED simultaneously high on the same edge: RESET wins.

Optional Feature:
Macro CLK_GEN_OUT_GATE_EN.
- Defined:
  - CLK_OUT1 = phase AND LOCKED (both registered on the same edge, so glitch-free).
  - CLK_OUT2 = pci_clk_in AND gate_n, where gate_n is LOCKED captured on the falling edge of pci_clk_in. This gives no runt pulses.
  - Both outputs are held low while not locked.
- Undefined: CLK_OUT1 and CLK_OUT2 run freely from reset release (CLK_OUT2 runs even during reset). LOCKED and CLK_VALID are unchanged.

Decomposition:
- Package clk_gen_pkg:
  - default LOCK_CYCLES and VALID_DELAY constants
  - lock-counter width constant (16)
  - lock-state typedef: enum CG_RESET, CG_LOCKING, CG_LOCKED
- One sub-module, clk_gen_lock_seq: counter, LOCKED and CLK_VALID delay. The divider and gating stay in the top.

Test Plan:
- RESET high for edges 0..127, low from edge 128 -> LOCKED rises at edge 192 and CLK_VALID at edge 194; CLK_IN_BUF tracks CLK_IN1 throughout.
- After lock, measure 20 CLK_OUT1 periods -> each exactly 2 input periods, high time = low time; CLK_OUT2 period = input period.
- RESET pulsed for one cycle at lock count 30 -> LOCKED stays 0; rises 64 edges after the pulse ends.
- RESET asserted while locked -> LOCKED and CLK_VALID low on that edge; CLK_OUT1 low; relock after 64 edges.
- With CLK_GEN_OUT_GATE_EN -> CLK_OUT1 and CLK_OUT2 constant 0 before LOCKED; the first CLK_OUT2 high pulse is full width (no runt).
- Without CLK_GEN_OUT_GATE_EN -> CLK_OUT1 toggles from the first edge after reset release while LOCKED=0.
